// File: rtl/approx_rc_adder_pipe_pkg.sv
// approx_adder_pkg: shared mode encodings and the approximation error predicate
// for the approximate ripple-carry adder pipeline.
package approx_adder_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // True when an OR-cell over the low k bits differs from the real add,
  // i.e. some bit position below k has both operand bits set.
  function automatic logic approx_err(input logic [63:0] a, input logic [63:0] b,
                                      input int k);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 64; i++)
      if (i < k) r = r | (a[i] & b[i]);
    return r;
  endfunction

endpackage

// File: rtl/approx_rc_adder_pipe_if.sv
// approx_rc_adder_pipe_if: operand/result valid-ready bus of the adder pipe.
//   master: drives operands + mode and out_ready (source/sink side)
//   slave : the adder; drives in_ready and the result beat
interface approx_rc_adder_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_err;

  modport master (output in_valid, in_a, in_b, in_mode, out_ready,
                  input  in_ready, out_valid, out_sum, out_err);
  modport slave  (input  in_valid, in_a, in_b, in_mode, out_ready,
                  output in_ready, out_valid, out_sum, out_err);
endinterface

// File: rtl/approx_rc_adder_pipe_rc_segment.sv
// rc_segment: one combinational SEG-bit slice of the carry chain.
//   a, b   slice operands (global bit offset OFFSET)
//   cin    carry from the previous slice
//   mode   MODE_APPROX turns bits below APPROX_BITS into OR-cells
//   sum    slice sum, cout carry out, err slice contribution to the error flag
module rc_segment
  import approx_adder_pkg::*;
#(
  parameter int SEG         = 4,
  parameter int OFFSET      = 0,
  parameter int APPROX_BITS = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic           mode,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           err
);

  // Number of this slice's bits that fall under the approximate region.
  localparam int NK = (APPROX_BITS <= OFFSET)     ? 0 :
                      (APPROX_BITS - OFFSET > SEG) ? SEG : APPROX_BITS - OFFSET;

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < SEG; i++) begin
      if (mode == MODE_APPROX && i < NK) begin
        // OR-cell kills the carry, so the first exact bit sees carry-in 0
        sum[i] = a[i] | b[i];
        c      = 1'b0;
      end else begin
        sum[i] = a[i] ^ b[i] ^ c;
        c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    cout = c;
    err  = (mode == MODE_APPROX) & approx_err(64'(a), 64'(b), NK);
  end

endmodule

// File: rtl/approx_rc_adder_pipe.sv
// approx_rc_adder_pipe: skewed pipeline ripple-carry adder, exact/approx per beat.
//   clk, rst_n   clock, async active-low reset
//   bus          operands/mode in, {carry,sum} + error flag out (valid/ready)
//   err_clr      synchronous clear of err_cnt (wins over a counting delivery)
//   err_cnt      saturating count of delivered beats with out_err = 1
// Stage s adds slice [s*SEG +: SEG] and registers it; the not-yet-added
// operand bits and the mode ride along, shrinking by SEG bits per stage.
module approx_rc_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4,
  parameter int STAGES      = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  approx_rc_adder_pipe_if.slave bus,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int SEG = WIDTH / STAGES;

  // index 0 = incoming beat, index s+1 = register after stage s
  logic [STAGES:0]            vld_pipe, rdy, c_p, err_p;
  logic [STAGES:0][WIDTH-1:0] sum_p;

  assign vld_pipe[0]  = bus.in_valid;
  assign c_p[0]       = 1'b0;
  assign err_p[0]     = 1'b0;
  assign sum_p[0]     = '0;
  assign rdy[STAGES]  = bus.out_ready;
  assign bus.in_ready = rdy[0];

  for (genvar s = 0; s < STAGES; s++) begin : stg
    localparam int RW = WIDTH - s*SEG;  // operand bits still to be added

    logic [RW-1:0]    a_i, b_i;
    logic             m_i;
    logic [SEG-1:0]   s_o;
    logic             c_o, e_o;
    logic [WIDTH-1:0] sum_n, sum_q;
    logic             v_q, c_q, e_q;

    // a stage may load when empty or when its content moves on this cycle
    assign rdy[s] = ~vld_pipe[s+1] | rdy[s+1];

    if (s == 0) begin : src
      assign a_i = bus.in_a;
      assign b_i = bus.in_b;
      assign m_i = bus.in_mode;
    end else begin : src
      assign a_i = stg[s-1].fwd.a_q;
      assign b_i = stg[s-1].fwd.b_q;
      assign m_i = stg[s-1].fwd.m_q;
    end

    rc_segment #(.SEG(SEG), .OFFSET(s*SEG), .APPROX_BITS(APPROX_BITS)) u_seg (
      .a(a_i[SEG-1:0]), .b(b_i[SEG-1:0]), .cin(c_p[s]), .mode(m_i),
      .sum(s_o), .cout(c_o), .err(e_o)
    );

    always_comb begin
      sum_n                = sum_p[s];
      sum_n[s*SEG +: SEG]  = s_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        e_q   <= 1'b0;
        sum_q <= '0;
      end else if (rdy[s]) begin
        v_q   <= vld_pipe[s];
        c_q   <= c_o;
        e_q   <= err_p[s] | e_o;
        sum_q <= sum_n;
      end
    end

    assign vld_pipe[s+1] = v_q;
    assign c_p[s+1]      = c_q;
    assign err_p[s+1]    = e_q;
    assign sum_p[s+1]    = sum_q;

    if (s < STAGES-1) begin : fwd
      logic [RW-SEG-1:0] a_q, b_q;
      logic              m_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          m_q <= MODE_EXACT;
        end else if (rdy[s]) begin
          a_q <= a_i[RW-1:SEG];
          b_q <= b_i[RW-1:SEG];
          m_q <= m_i;
        end
      end
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_sum   = {c_p[STAGES], sum_p[STAGES]};
  assign bus.out_err   = err_p[STAGES];

  logic deliver;
  assign deliver = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (deliver && bus.out_err && err_cnt != {CNT_W{1'b1}})
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule
